// File: rtl/jt51_lin_dec_if.sv
// Operator-path sample bus between the log-sine lookup, the linear decoder and the accumulator.
// The master drives the log-domain sample; the slave returns the signed linear result.
interface jt51_lin_dec_if;
    logic [11:0] logsin;
    logic [9:0]  eg_att;
    logic        sign_in;
    logic        valid_in;
    logic [13:0] lin;
    logic        valid_out;

    modport master (
        output logsin,
        output eg_att,
        output sign_in,
        output valid_in,
        input  lin,
        input  valid_out
    );

    modport slave (
        input  logsin,
        input  eg_att,
        input  sign_in,
        input  valid_in,
        output lin,
        output valid_out
    );
endinterface

// File: rtl/jt51_lin_dec.sv
// Log-to-linear decoder: adds envelope attenuation to the log-sine value, then converts
// the 4.8 log sum to a signed 14-bit linear sample via an exponential ROM and barrel shift.
module jt51_lin_dec (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    jt51_lin_dec_if.slave      bus
);

    // 2^(-1/256) in Q48; entries are built by repeated multiplication at elaboration time
    localparam logic [63:0] EXP_STEP = 64'd280713884160287;

    function automatic logic [10:0] exp_entry(input int k);
        logic [127:0] acc;
        logic [127:0] rnd;
        acc = 128'd1024 << 48;
        for (int i = 0; i < k; i++) begin
            acc = (acc * {64'd0, EXP_STEP}) >> 48;
        end
        rnd = (acc + (128'd1 << 47)) >> 48;
        return rnd[10:0];
    endfunction

    logic [10:0] exp_rom [256];

    for (genvar k = 0; k < 256; k++) begin : g_rom
        localparam logic [10:0] ENTRY = exp_entry(k);
        assign exp_rom[k] = ENTRY;
    end

    logic [12:0] att_s1;
    logic        sign_s1;
    logic        valid_s1;

    logic [10:0] m_s2;
    logic [4:0]  s_s2;
    logic        sign_s2;
    logic        valid_s2;

    logic [13:0] lin_s3;
    logic        valid_s3;

    logic [12:0] mag;
    logic [13:0] lin_next;

    // Shifting the 13-bit mantissa by 13 or more naturally yields zero
    always_comb begin
        mag      = {m_s2, 2'b00} >> s_s2;
        lin_next = sign_s2 ? (14'd0 - {1'b0, mag}) : {1'b0, mag};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            att_s1   <= 13'd0;
            sign_s1  <= 1'b0;
            valid_s1 <= 1'b0;
            m_s2     <= 11'd0;
            s_s2     <= 5'd0;
            sign_s2  <= 1'b0;
            valid_s2 <= 1'b0;
            lin_s3   <= 14'd0;
            valid_s3 <= 1'b0;
        end else if (cen) begin
            att_s1   <= {1'b0, bus.logsin} + {1'b0, bus.eg_att, 2'b00};
            sign_s1  <= bus.sign_in;
            valid_s1 <= bus.valid_in;
            m_s2     <= exp_rom[att_s1[7:0]];
            s_s2     <= att_s1[12:8];
            sign_s2  <= sign_s1;
            valid_s2 <= valid_s1;
            lin_s3   <= lin_next;
            valid_s3 <= valid_s2;
        end
    end

    assign bus.lin       = lin_s3;
    assign bus.valid_out = valid_s3;

endmodule

// File: tb/tb_jt51_lin_dec.sv
// Randomised and directed bench for jt51_lin_dec with a queue-based scoreboard.
module tb_jt51_lin_dec;

    logic clk = 1'b0;
    logic rst;
    logic cen;

    jt51_lin_dec_if bus ();

    jt51_lin_dec dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [13:0] lin;
    } exp_t;

    exp_t exp_q[$];

    int n_vec   = 0;
    int n_bad   = 0;
    int n_valid = 0;

    // Reference: round(1024 * 2^-frac), scaled by 4, divided by 2^int, then signed
    function automatic logic [13:0] ref_lin(input logic [11:0] ls, input logic [9:0] eg,
                                            input logic sg);
        int att, f, s, e, mag, val;
        att = int'(ls) + 4 * int'(eg);
        f   = att % 256;
        s   = att / 256;
        e   = int'(1024.0 * $pow(2.0, -f / 256.0));
        mag = (s >= 13) ? 0 : ((e * 4) >> s);
        val = sg ? -mag : mag;
        return 14'(val);
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Sampler: each cen-qualified edge enters one expectation; reset discards in-flight work
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_q.push_back('{v: 1'b0, lin: 14'd0});
            exp_q.push_back('{v: 1'b0, lin: 14'd0});
        end else if (cen) begin
            exp_q.push_back('{v: bus.valid_in,
                              lin: ref_lin(bus.logsin, bus.eg_att, bus.sign_in)});
        end
    end

    logic        m_rst, m_cen;
    logic        last_v;
    logic        lin_known;
    logic [13:0] last_lin;
    exp_t        e;

    // Monitor: compares outputs 1 time unit after each edge
    always @(posedge clk) begin
        m_rst = rst;
        m_cen = cen;
        #1;
        if (m_rst) begin
            check("rst_valid", {13'd0, bus.valid_out}, 14'd0);
            check("rst_lin", bus.lin, 14'd0);
            last_v    = 1'b0;
            last_lin  = 14'd0;
            lin_known = 1'b1;
        end else if (m_cen) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL qempty: got output with no expectation, expected queued entry at %0t",
                         $time);
            end else begin
                e = exp_q.pop_front();
                check("valid", {13'd0, bus.valid_out}, {13'd0, e.v});
                if (e.v) begin
                    check("lin", bus.lin, e.lin);
                    n_valid++;
                end
                last_v    = e.v;
                last_lin  = e.lin;
                lin_known = e.v;
            end
        end else begin
            check("hold_valid", {13'd0, bus.valid_out}, {13'd0, last_v});
            if (lin_known) check("hold_lin", bus.lin, last_lin);
        end
    end

    task automatic drive(input logic [11:0] ls, input logic [9:0] eg, input logic sg,
                         input logic v, input logic c, input logic r);
        @(negedge clk);
        bus.logsin   = ls;
        bus.eg_att   = eg;
        bus.sign_in  = sg;
        bus.valid_in = v;
        cen          = c;
        rst          = r;
        if (!c) begin
            #2;
            bus.logsin   = 12'($urandom);
            bus.eg_att   = 10'($urandom);
            bus.sign_in  = 1'($urandom);
            bus.valid_in = 1'($urandom);
        end
    endtask

    logic [11:0] dir_ls [10];
    logic [9:0]  dir_eg [10];

    initial begin
        rst          = 1'b1;
        cen          = 1'b0;
        bus.logsin   = 12'd0;
        bus.eg_att   = 10'd0;
        bus.sign_in  = 1'b0;
        bus.valid_in = 1'b0;

        drive(12'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(12'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(12'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1);

        dir_ls = '{12'h000, 12'h080, 12'h100, 12'h0FF, 12'h000,
                   12'hC00, 12'hD00, 12'hFFF, 12'h001, 12'hBFF};
        dir_eg = '{10'h000, 10'h000, 10'h000, 10'h000, 10'h040,
                   10'h000, 10'h000, 10'h3FF, 10'h000, 10'h000};
        for (int i = 0; i < 10; i++) begin
            drive(dir_ls[i], dir_eg[i], 1'b0, 1'b1, 1'b1, 1'b0);
            drive(dir_ls[i], dir_eg[i], 1'b1, 1'b1, 1'b1, 1'b0);
        end

        // cen pattern 1,0,0 with random glitches while disabled
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0)
                drive(12'($urandom), 10'($urandom_range(0, 63)), 1'($urandom), 1'b1, 1'b1, 1'b0);
            else
                drive(12'($urandom), 10'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        end

        // Reset with three valid samples in flight, reset edge has cen low
        for (int i = 0; i < 3; i++)
            drive(12'($urandom_range(0, 1023)), 10'd0, 1'($urandom), 1'b1, 1'b1, 1'b0);
        drive(12'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            drive(12'($urandom), 10'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b0);

        // Full log-sine sweep, both signs
        for (int sg = 0; sg < 2; sg++)
            for (int ls = 0; ls < 4096; ls++)
                drive(12'(ls), 10'd0, 1'(sg), 1'b1, 1'b1, 1'b0);

        // Random traffic with random cen duty and occasional reset
        for (int i = 0; i < 3000; i++)
            drive(12'($urandom), 10'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));

        for (int i = 0; i < 4; i++)
            drive(12'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        n_vec++;
        if (n_valid < 8192) begin
            n_bad++;
            $display("FAIL valid_count: got %0d valid outputs, expected at least 8192", n_valid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
